// File: rtl/mux_shift_bank.sv
// Multi-channel serial shift register bank with per-channel input mux, parallel load and fill flag.
// Optional macro MUX_SHIFT_BANK_CASCADE_EN adds a cascade input chaining channels into one long register.
module mux_shift_bank #(
    parameter int  CHANNELS = 2,
    parameter int  DEPTH    = 8,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr,
    input  logic [CHANNELS-1:0]         shift_en,
    input  logic [CHANNELS-1:0]         sel,
    input  logic [CHANNELS-1:0]         i0,
    input  logic [CHANNELS-1:0]         i1,
    input  logic [CHANNELS-1:0]         load,
    input  logic [CHANNELS*DEPTH-1:0]   load_data,
`ifdef MUX_SHIFT_BANK_CASCADE_EN
    input  logic                        cascade,
`endif
    output logic [CHANNELS-1:0]         q,
    output logic [CHANNELS-1:0]         q_n,
    output logic [CHANNELS*DEPTH-1:0]   par_out,
    output logic [CHANNELS-1:0]         full
);

    typedef logic [DEPTH-1:0] stage_t;
    typedef logic [CW-1:0]    cnt_t;

    stage_t [CHANNELS-1:0] sr_q, sr_d;
    cnt_t   [CHANNELS-1:0] cnt_q, cnt_d;

    logic [CHANNELS-1:0] last_stage;
    logic [CHANNELS-1:0] mux_din;
    logic [CHANNELS-1:0] din;

    always_comb begin
        last_stage = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            last_stage[k] = sr_q[k][DEPTH-1];
        end
    end

    // Plain AND/OR mux: an X on the unselected input cannot reach din.
    assign mux_din = (sel & i1) | (~sel & i0);

`ifdef MUX_SHIFT_BANK_CASCADE_EN
    // In cascade mode channel k>0 is fed from the pre-edge last stage of channel k-1.
    assign din = cascade ? ((last_stage << 1) | (mux_din & CHANNELS'(1))) : mux_din;
`else
    assign din = mux_din;
`endif

    // NOTE: next-state defaults to the current state first so no path can infer a latch.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clr) begin
            sr_d  = '0;
            cnt_d = '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (load[k]) begin
                    sr_d[k]  = load_data[k*DEPTH +: DEPTH];
                    cnt_d[k] = '0;
                end else if (shift_en[k]) begin
                    sr_d[k] = {sr_q[k][DEPTH-2:0], din[k]};
                    if (cnt_q[k] != CW'(DEPTH)) begin
                        cnt_d[k] = cnt_q[k] + CW'(1);
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign q       = last_stage;
    assign q_n     = ~last_stage;
    assign par_out = sr_q;

    always_comb begin
        full = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            full[k] = (cnt_q[k] == CW'(DEPTH));
        end
    end

endmodule

// File: tb/tb_mux_shift_bank.sv
// Directed self-checking bench for mux_shift_bank (CHANNELS=2, DEPTH=8); cascade scenario runs
// only when MUX_SHIFT_BANK_CASCADE_EN is defined.
module tb_mux_shift_bank;

    localparam int CHANNELS = 2;
    localparam int DEPTH    = 8;

    logic                      clk;
    logic                      reset;
    logic                      clr;
    logic [CHANNELS-1:0]       shift_en;
    logic [CHANNELS-1:0]       sel;
    logic [CHANNELS-1:0]       i0;
    logic [CHANNELS-1:0]       i1;
    logic [CHANNELS-1:0]       load;
    logic [CHANNELS*DEPTH-1:0] load_data;
    logic                      cascade;
    logic [CHANNELS-1:0]       q;
    logic [CHANNELS-1:0]       q_n;
    logic [CHANNELS*DEPTH-1:0] par_out;
    logic [CHANNELS-1:0]       full;

    int vectors;
    int miscompares;

    mux_shift_bank #(.CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .shift_en  (shift_en),
        .sel       (sel),
        .i0        (i0),
        .i1        (i1),
        .load      (load),
        .load_data (load_data),
`ifdef MUX_SHIFT_BANK_CASCADE_EN
        .cascade   (cascade),
`endif
        .q         (q),
        .q_n       (q_n),
        .par_out   (par_out),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset     = 1'b0;
        clr       = 1'b0;
        shift_en  = '0;
        sel       = '0;
        i0        = '0;
        i1        = '0;
        load      = '0;
        load_data = '0;
        cascade   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset     = 1'b1;
        load      = '1;
        shift_en  = '1;
        load_data = '1;
        i0        = '1;
        i1        = '1;
        tick();
        tick();
        vectors++;
        if (q !== 2'b00) begin miscompares++; $display("FAIL reset_q got=%b want=%b", q, 2'b00); end
        vectors++;
        if (q_n !== 2'b11) begin miscompares++; $display("FAIL reset_q_n got=%b want=%b", q_n, 2'b11); end
        vectors++;
        if (par_out !== 16'h0000) begin miscompares++; $display("FAIL reset_par_out got=%h want=%h", par_out, 16'h0000); end
        vectors++;
        if (full !== 2'b00) begin miscompares++; $display("FAIL reset_full got=%b want=%b", full, 2'b00); end
        idle_inputs();
    endtask

    task automatic test_serial_fill();
        logic [7:0] pat;
        pat = 8'b10110010;
        idle_inputs();
        shift_en = 2'b01;
        sel      = 2'b00;
        i1       = 2'b01;   // unselected input for ch0 held opposite to catch a wrong mux
        for (int i = 0; i < 8; i++) begin
            i0 = {1'b1, pat[7-i]};
            tick();
            if (i < 7) begin
                vectors++;
                if (full[0] !== 1'b0) begin miscompares++; $display("FAIL fill_early_full edge=%0d got=%b want=0", i + 1, full[0]); end
            end
        end
        vectors++;
        if (par_out[7:0] !== 8'b10110010) begin miscompares++; $display("FAIL fill_par_out got=%b want=%b", par_out[7:0], 8'b10110010); end
        vectors++;
        if (q[0] !== 1'b1) begin miscompares++; $display("FAIL fill_q0 got=%b want=1", q[0]); end
        vectors++;
        if (full[0] !== 1'b1) begin miscompares++; $display("FAIL fill_full0 got=%b want=1", full[0]); end
        vectors++;
        if (par_out[15:8] !== 8'h00 || full[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_ch1_idle got=%h/%b want=00/0", par_out[15:8], full[1]);
        end
        idle_inputs();
    endtask

    task automatic test_select_saturation();
        idle_inputs();
        shift_en = 2'b10;
        sel      = 2'b10;
        i1       = 2'b10;
        i0       = 2'b01;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 7) begin
                vectors++;
                if (full[1] !== 1'b1) begin miscompares++; $display("FAIL sel_full_at8 got=%b want=1", full[1]); end
            end
        end
        vectors++;
        if (par_out[15:8] !== 8'hFF) begin miscompares++; $display("FAIL sel_i1_par got=%h want=%h", par_out[15:8], 8'hFF); end
        vectors++;
        if (full[1] !== 1'b1) begin miscompares++; $display("FAIL sel_saturate_full got=%b want=1", full[1]); end
        vectors++;
        if (par_out[7:0] !== 8'hB2) begin miscompares++; $display("FAIL sel_ch0_hold got=%h want=%h", par_out[7:0], 8'hB2); end
        sel = 2'b00;
        tick();
        vectors++;
        if (par_out[15:8] !== 8'hFE) begin miscompares++; $display("FAIL sel_i0_par got=%h want=%h", par_out[15:8], 8'hFE); end
        vectors++;
        if (full[1] !== 1'b1) begin miscompares++; $display("FAIL sel_i0_full got=%b want=1", full[1]); end
        idle_inputs();
    endtask

    task automatic test_load_priority();
        idle_inputs();
        load      = 2'b01;
        shift_en  = 2'b01;
        i0        = 2'b11;
        load_data = 16'h3C81;
        tick();
        vectors++;
        if (par_out[7:0] !== 8'h81) begin miscompares++; $display("FAIL load_par got=%h want=%h", par_out[7:0], 8'h81); end
        vectors++;
        if (full[0] !== 1'b0) begin miscompares++; $display("FAIL load_full0 got=%b want=0", full[0]); end
        vectors++;
        if (q[0] !== 1'b1 || q_n[0] !== 1'b0) begin miscompares++; $display("FAIL load_q got=%b/%b want=1/0", q[0], q_n[0]); end
        vectors++;
        if (par_out[15:8] !== 8'hFE || full[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL load_ch1_untouched got=%h/%b want=fe/1", par_out[15:8], full[1]);
        end
        idle_inputs();
        tick();
        vectors++;
        if (par_out !== 16'hFE81) begin miscompares++; $display("FAIL hold_par got=%h want=%h", par_out, 16'hFE81); end
    endtask

    task automatic test_clr_vs_load();
        idle_inputs();
        clr       = 1'b1;
        load      = 2'b11;
        shift_en  = 2'b11;
        load_data = 16'hFFFF;
        tick();
        vectors++;
        if (par_out !== 16'h0000) begin miscompares++; $display("FAIL clr_par got=%h want=%h", par_out, 16'h0000); end
        vectors++;
        if (full !== 2'b00 || q_n !== 2'b11) begin miscompares++; $display("FAIL clr_flags got=%b/%b want=00/11", full, q_n); end
        clr       = 1'b0;
        load_data = 16'hA55A;
        tick();
        vectors++;
        if (par_out !== 16'hA55A) begin miscompares++; $display("FAIL clr_resume_par got=%h want=%h", par_out, 16'hA55A); end
        vectors++;
        if (q !== 2'b10 || q_n !== 2'b01) begin miscompares++; $display("FAIL clr_resume_q got=%b/%b want=10/01", q, q_n); end
        idle_inputs();
    endtask

    task automatic test_reset_midstream();
        idle_inputs();
        shift_en = 2'b11;
        i0       = 2'b11;
        tick();
        tick();
        reset = 1'b1;
        tick();
        vectors++;
        if (par_out !== 16'h0000 || full !== 2'b00) begin
            miscompares++;
            $display("FAIL midreset_clear got=%h/%b want=0000/00", par_out, full);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (par_out !== 16'h0101 || full !== 2'b00) begin
            miscompares++;
            $display("FAIL midreset_resume got=%h/%b want=0101/00", par_out, full);
        end
        idle_inputs();
    endtask

`ifdef MUX_SHIFT_BANK_CASCADE_EN
    task automatic test_cascade();
        idle_inputs();
        load      = 2'b11;
        load_data = 16'h0080;
        tick();
        idle_inputs();
        cascade  = 1'b1;
        shift_en = 2'b11;
        i0       = 2'b00;
        i1       = 2'b10;
        sel      = 2'b10;   // ch1 mux would pick 1 if cascade were ignored
        tick();
        vectors++;
        if (par_out !== 16'h0100) begin miscompares++; $display("FAIL cascade_par got=%h want=%h", par_out, 16'h0100); end
        vectors++;
        if (full !== 2'b00) begin miscompares++; $display("FAIL cascade_full got=%b want=00", full); end
        idle_inputs();
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle_inputs();
        test_reset();
        test_serial_fill();
        test_select_saturation();
        test_load_priority();
        test_clr_vs_load();
        test_reset_midstream();
`ifdef MUX_SHIFT_BANK_CASCADE_EN
        test_cascade();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
